// File: rtl/dcsformer_host.sv
// Host-side driver for the DCSformer attention core: buffers one job, streams it to the core, collects the results.
// Optional stall watchdog is built only when DCSH_TIMEOUT_EN is defined.
module dcsformer_host #(
  parameter int N_IN    = 128,
  parameter int N_W     = 8,
  parameter int N_OUT   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_en,
  input  logic [7:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        i_valid,
  output logic [7:0]  i_data,
  output logic        w_valid,
  output logic [7:0]  w_data,
  input  logic        w_ready,
  input  logic        o_valid,
  input  logic [31:0] o_data
);
  localparam int IW = $clog2(N_IN);
  localparam int WW = $clog2(N_W);
  localparam int OW = $clog2(N_OUT);

  typedef enum logic [2:0] {IDLE, SEND_I, WAIT_WR, SEND_W, COLLECT, FIN} state_t;

  state_t        state_r;
  logic [7:0]    act_r [N_IN];
  logic [7:0]    wt_r  [N_W];
  logic [31:0]   res_r [N_OUT];
  logic [IW-1:0] icnt_r;
  logic [WW-1:0] wcnt_r;
  logic [OW-1:0] ocnt_r;
  logic          busy_r, done_r, err_r, i_valid_r, w_valid_r;
  logic [7:0]    i_data_r, w_data_r;

  logic          ld_ok_s, ld_act_s, ld_wt_s, start_ok_s, o_take_s, stall_hit_s;
  logic [7:0]    first_i_s;

  assign ld_ok_s    = ld_en && (state_r == IDLE || state_r == FIN);
  assign ld_act_s   = ld_ok_s && (ld_addr[7] == 1'b0);
  assign ld_wt_s    = ld_ok_s && (ld_addr[7:3] == 5'b10000);
  assign start_ok_s = start && (state_r == IDLE);
  assign o_take_s   = o_valid && (state_r == COLLECT);
  // A same-cycle write to slot 0 must reach the first beat, so bypass the buffer.
  assign first_i_s  = (ld_act_s && ld_addr[IW-1:0] == {IW{1'b0}}) ? ld_data : act_r[0];

`ifdef DCSH_TIMEOUT_EN
  logic              stall_wait_s;
  logic [IW+3-1:0]   unused_pad_s;
  localparam int SW = $clog2(TIMEOUT);
  logic [SW-1:0]     stall_r;

  assign unused_pad_s = '0;
  assign stall_wait_s = (state_r == WAIT_WR && !w_ready) || (state_r == COLLECT && !o_valid);
  assign stall_hit_s  = stall_wait_s && (stall_r == SW'(TIMEOUT - 1));

  // Stall counter: counts idle cycles while waiting on the core, cleared by any beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_r <= '0;
    end else if (stall_wait_s) begin
      stall_r <= stall_r + 1'b1;
    end else begin
      stall_r <= '0;
    end
  end
`else
  assign stall_hit_s = 1'b0;
`endif

  // Job buffers: not reset; loader writes only while idle, results cleared on accepted start.
  always_ff @(posedge clk) begin
    if (ld_act_s) act_r[ld_addr[IW-1:0]] <= ld_data;
    if (ld_wt_s)  wt_r[ld_addr[WW-1:0]]  <= ld_data;
    if (start_ok_s) begin
      for (int j = 0; j < N_OUT; j++) res_r[j] <= 32'd0;
    end else if (o_take_s) begin
      res_r[ocnt_r] <= o_data;
    end
  end

  // Sequencer with registered strobes towards the core and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      icnt_r    <= '0;
      wcnt_r    <= '0;
      ocnt_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      i_valid_r <= 1'b0;
      w_valid_r <= 1'b0;
      i_data_r  <= 8'd0;
      w_data_r  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            state_r   <= SEND_I;
            busy_r    <= 1'b1;
            err_r     <= 1'b0;
            i_valid_r <= 1'b1;
            i_data_r  <= first_i_s;
            icnt_r    <= '0;
          end
        end
        SEND_I: begin
          if (icnt_r == IW'(N_IN - 1)) begin
            i_valid_r <= 1'b0;
            state_r   <= WAIT_WR;
          end else begin
            icnt_r   <= icnt_r + 1'b1;
            i_data_r <= act_r[icnt_r + 1'b1];
          end
        end
        WAIT_WR: begin
          if (stall_hit_s) begin
            err_r     <= 1'b1;
            i_valid_r <= 1'b0;
            w_valid_r <= 1'b0;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= FIN;
          end else if (w_ready) begin
            // The core thresholds in the w_ready cycle; weights start one cycle later.
            w_valid_r <= 1'b1;
            w_data_r  <= wt_r[0];
            wcnt_r    <= '0;
            state_r   <= SEND_W;
          end
        end
        SEND_W: begin
          if (wcnt_r == WW'(N_W - 1)) begin
            w_valid_r <= 1'b0;
            ocnt_r    <= '0;
            state_r   <= COLLECT;
          end else begin
            wcnt_r   <= wcnt_r + 1'b1;
            w_data_r <= wt_r[wcnt_r + 1'b1];
          end
        end
        COLLECT: begin
          if (stall_hit_s) begin
            err_r     <= 1'b1;
            i_valid_r <= 1'b0;
            w_valid_r <= 1'b0;
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= FIN;
          end else if (o_valid) begin
            if (ocnt_r == OW'(N_OUT - 1)) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= FIN;
            end else begin
              ocnt_r <= ocnt_r + 1'b1;
            end
          end
        end
        FIN: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          i_valid_r <= 1'b0;
          w_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;
  assign i_valid = i_valid_r;
  assign i_data  = i_data_r;
  assign w_valid = w_valid_r;
  assign w_data  = w_data_r;
  assign rd_data = res_r[rd_addr];
endmodule
